// File: rtl/enc_pkg.sv
// Shared defaults and mode constants for the 16-to-4 request encoder.
package enc_pkg;

  localparam int N_DEF      = 16;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Code width for a power-of-two line count (minimum one bit).
  function automatic int log2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int W_DEF = log2w(N_DEF);

endpackage

// File: rtl/enc_rr_sel.sv
// Combinational selector: highest set index (fixed) or first set index
// after ptr with wrap (round-robin).
module enc_rr_sel
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = log2w(N)
) (
  input  logic [N-1:0] p,
  input  logic [W-1:0] ptr,
  input  logic         rr,
  output logic [W-1:0] sel,
  output logic         any
);

  logic [W-1:0]   start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   first_rot;
  logic [W-1:0]   highest;

  // Rotating the doubled vector puts index ptr+1 at bit 0; W-bit
  // arithmetic gives the modulo-N wrap for free.
  assign start = ptr + W'(1);
  assign dbl   = {p, p} >> start;
  assign rot   = dbl[N-1:0];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    first_rot = '0;
    highest   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first_rot = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (p[i]) highest = W'(i);
    end
  end

  assign any = |p;
  assign sel = rr ? (start + first_rot) : highest;

endmodule

// File: rtl/enc_16to4_req.sv
// Sequential request encoder: accumulates request pulses as pending bits
// and hands them out one code at a time over a valid/ready slot.
module enc_16to4_req
  import enc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = log2w(N),
  parameter int RR = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic [N-1:0] D,
  input  logic         rdy,
  output logic         V,
  output logic [W-1:0] A,
  output logic [N-1:0] P,
  output logic         ovf,
  input  logic         clr_ovf
);

  logic [N-1:0] p_q, p_d;
  logic         v_q, v_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         ovf_q, ovf_d;

  logic [W-1:0] sel;
  logic         any;
  logic         load;
  logic [N-1:0] clear_mask;
  logic [N-1:0] kept;

  enc_rr_sel #(.N(N), .W(W)) u_sel (
    .p   (p_q),
    .ptr (ptr_q),
    .rr  (RR == MODE_RR),
    .sel (sel),
    .any (any)
  );

  assign load       = E & any & (~v_q | rdy);
  assign clear_mask = load ? (N'(1) << sel) : '0;
  assign kept       = p_q & ~clear_mask;

  always_comb begin
    p_d   = kept | D;
    v_d   = v_q;
    a_d   = a_q;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    if (load) begin
      v_d = 1'b1;
      a_d = sel;
      if (RR == MODE_RR) ptr_d = sel;
    end else if (v_q && rdy) begin
      v_d = 1'b0;
    end
    // A repeat request on a bit that is still pending is a drop; set beats clear.
    if (|(D & kept))  ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      v_q   <= 1'b0;
      a_q   <= '0;
      ptr_q <= '1;
      ovf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      v_q   <= v_d;
      a_q   <= a_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  assign V   = v_q;
  assign A   = a_q;
  assign P   = p_q;
  assign ovf = ovf_q;

endmodule
